// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: conversion FSM states,
// digit count and active-low seven-segment encodings (gfedcba).
package score_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 5;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_encode = SEG_0;
            4'd1:    seg_encode = SEG_1;
            4'd2:    seg_encode = SEG_2;
            4'd3:    seg_encode = SEG_3;
            4'd4:    seg_encode = SEG_4;
            4'd5:    seg_encode = SEG_5;
            4'd6:    seg_encode = SEG_6;
            4'd7:    seg_encode = SEG_7;
            4'd8:    seg_encode = SEG_8;
            4'd9:    seg_encode = SEG_9;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD (shift-add-3, one bit per clock); result 18 clocks
// after a score change, published atomically. No backpressure: changes during a conversion wait for IDLE.
module bin2bcd_seq
    import score_display_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] score_i,
    output logic [19:0] bcd_o,
    output logic        busy_o
);

    state_t      state_q, state_d;
    logic [15:0] bin_q, bin_d;
    logic [15:0] cap_q, cap_d;
    logic [15:0] last_q, last_d;
    logic [19:0] sr_q, sr_d;
    logic [19:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [19:0] corr;

    // Nibbles >= 5 would exceed 9 after doubling, so pre-add 3 before the shift.
    always_comb begin
        corr = sr_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sr_q[4*i +: 4] >= 4'd5) begin
                corr[4*i +: 4] = sr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        cap_d   = cap_q;
        last_d  = last_q;
        sr_d    = sr_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (score_i != last_q) begin
                    cap_d   = score_i;
                    bin_d   = score_i;
                    sr_d    = 20'd0;
                    cnt_d   = 5'd0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = {corr[18:0], bin_q[15]};
                bin_d = {bin_q[14:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = sr_q;
                last_d  = cap_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            bin_q   <= 16'd0;
            cap_q   <= 16'd0;
            last_q  <= 16'd0;
            sr_q    <= 20'd0;
            bcd_q   <= 20'd0;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            cap_q   <= cap_d;
            last_q  <= last_d;
            sr_q    <= sr_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign bcd_o  = bcd_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/score_display.sv
// Drives the 8-digit active-low seven-segment display from the score, leading zeros blanked;
// An/seg are registered one clock behind the scan counter. No backpressure.
module score_display
    import score_display_pkg::*;
#(
    parameter int SCAN_DIV = 18
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [15:0] score,
    output logic [7:0]  An,
    output logic [6:0]  seg,
    output logic        Dp,
    output logic [19:0] bcd,
    output logic        busy
);

    logic [SCAN_DIV-1:0] scan_q;
    logic [2:0]          digit;
    logic [7:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic [NUM_DIGITS-1:0] nz;
    logic [7:0]          lit_vec;
    logic [31:0]         bcd_pad;
    logic [3:0]          nib;
    logic [19:0]         bcd_w;

    bin2bcd_seq u_bin2bcd (
        .clk_i   (clk),
        .rst_ni  (Reset),
        .score_i (score),
        .bcd_o   (bcd_w),
        .busy_o  (busy)
    );

    assign digit   = scan_q[SCAN_DIV-1 -: 3];
    assign bcd_pad = {12'h000, bcd_w};
    assign nib     = bcd_pad[{digit, 2'b00} +: 4];

    always_comb begin
        nz = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nz[i] = |bcd_w[4*i +: 4];
        end
    end

    // A digit is lit if it or any more-significant digit is nonzero; digit 0 always lit.
    assign lit_vec[0]   = 1'b1;
    assign lit_vec[1]   = |nz[4:1];
    assign lit_vec[2]   = |nz[4:2];
    assign lit_vec[3]   = |nz[4:3];
    assign lit_vec[4]   = nz[4];
    assign lit_vec[7:5] = 3'b000;

    always_comb begin
        an_d  = 8'hFF;
        seg_d = SEG_BLANK;
        if (lit_vec[digit]) begin
            an_d  = ~(8'd1 << digit);
            seg_d = seg_encode(nib);
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            scan_q <= '0;
            an_q   <= 8'hFF;
            seg_q  <= SEG_BLANK;
        end else begin
            scan_q <= scan_q + {{(SCAN_DIV-1){1'b0}}, 1'b1};
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign An  = an_q;
    assign seg = seg_q;
    assign Dp  = 1'b1;
    assign bcd = bcd_w;

endmodule

// File: tb/tb_score_display.sv
// Randomized and directed bench for score_display with a decimal-arithmetic reference model.
module tb_score_display;

    logic        clk = 1'b0;
    logic        Reset;
    logic [15:0] score;
    logic [7:0]  An;
    logic [6:0]  seg;
    logic        Dp;
    logic [19:0] bcd;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int edges       = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    score_display #(.SCAN_DIV(6)) dut (
        .clk   (clk),
        .Reset (Reset),
        .score (score),
        .An    (An),
        .seg   (seg),
        .Dp    (Dp),
        .bcd   (bcd),
        .busy  (busy)
    );

    // Clock edges since reset release; the display after edge e shows scan slot e-1.
    always @(posedge clk or negedge Reset) begin
        if (!Reset) edges <= 0;
        else        edges <= edges + 1;
    end

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        score = 16'd0;
        #1 Reset = 1'b0;
        #1;
        vectors++; if (An !== 8'hFF) begin miscompares++; $display("FAIL reset_An got %h want ff", An); end
        vectors++; if (seg !== 7'h7F) begin miscompares++; $display("FAIL reset_seg got %h want 7f", seg); end
        vectors++; if (Dp !== 1'b1) begin miscompares++; $display("FAIL reset_Dp got %b want 1", Dp); end
        vectors++; if (bcd !== 20'h0) begin miscompares++; $display("FAIL reset_bcd got %h want 00000", bcd); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge clk);
        Reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic run_conversion(input logic [15:0] v, input logic [19:0] prev);
        int n;
        logic [19:0] exp_bcd;
        exp_bcd = to_bcd(int'(v));
        @(negedge clk);
        score = v;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 40) begin
            vectors++;
            if (bcd !== prev) begin
                miscompares++;
                $display("FAIL partial_bcd v=%0d got %h want %h", v, bcd, prev);
            end
            n++;
            @(negedge clk);
        end
        vectors++; if (n != 17) begin miscompares++; $display("FAIL busy_len v=%0d got %0d want 17", v, n); end
        vectors++; if (bcd !== exp_bcd) begin miscompares++; $display("FAIL conv_bcd v=%0d got %h want %h", v, bcd, exp_bcd); end
    endtask

    task automatic test_scan(input int v);
        int k, p;
        bit lit;
        logic [19:0] d;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        d = to_bcd(v);
        @(negedge clk);
        for (int c = 0; c < 64; c++) begin
            k = ((edges - 1) % 64) / 8;
            p = 1;
            for (int j = 0; j < k; j++) p = p * 10;
            lit = (k == 0) || (k < 5 && v >= p);
            exp_an  = lit ? ~(8'd1 << k) : 8'hFF;
            exp_seg = lit ? seg_tab[int'(d[4*k +: 4])] : 7'h7F;
            vectors++;
            if (An !== exp_an || seg !== exp_seg || Dp !== 1'b1) begin
                miscompares++;
                $display("FAIL scan v=%0d slot=%0d got An=%h seg=%b Dp=%b want An=%h seg=%b Dp=1",
                         v, k, An, seg, Dp, exp_an, exp_seg);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_1234();
        run_conversion(16'd1234, 20'h00000);
        test_scan(1234);
    endtask

    task automatic test_max();
        run_conversion(16'd65535, 20'h01234);
        test_scan(65535);
    endtask

    task automatic test_zero();
        run_conversion(16'd0, 20'h65535);
        test_scan(0);
    endtask

    task automatic test_back_to_back();
        int changes;
        logic [19:0] seen;
        changes = 0;
        seen = bcd;
        @(negedge clk);
        score = 16'd100;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 3) score = 16'd200;
            if (bcd !== seen) begin
                changes++;
                vectors++;
                if (changes == 1 && (c != 18 || bcd !== 20'h00100)) begin
                    miscompares++;
                    $display("FAIL b2b_first got %h at %0d want 00100 at 18", bcd, c);
                end else if (changes == 2 && (c != 36 || bcd !== 20'h00200)) begin
                    miscompares++;
                    $display("FAIL b2b_second got %h at %0d want 00200 at 36", bcd, c);
                end else if (changes > 2) begin
                    miscompares++;
                    $display("FAIL b2b_extra got %h at %0d want no change", bcd, c);
                end
                seen = bcd;
            end
        end
        vectors++; if (changes != 2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", changes); end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        score = 16'd42;
        repeat (9) @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy got %b want 1", busy); end
        Reset = 1'b0;
        #1;
        vectors++; if (An !== 8'hFF) begin miscompares++; $display("FAIL mid_rst_An got %h want ff", An); end
        vectors++; if (seg !== 7'h7F) begin miscompares++; $display("FAIL mid_rst_seg got %h want 7f", seg); end
        vectors++; if (bcd !== 20'h0) begin miscompares++; $display("FAIL mid_rst_bcd got %h want 00000", bcd); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        @(negedge clk);
        Reset = 1'b1;
        n = 0;
        while (bcd !== 20'h00042 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++; if (n != 18) begin miscompares++; $display("FAIL mid_latency got %0d want 18 bcd=%h", n, bcd); end
        test_scan(42);
    endtask

    task automatic test_random();
        logic [15:0] v, last;
        last = 16'd42;
        for (int i = 0; i < 6; i++) begin
            v = 16'($urandom_range(1, 65535));
            if (v == last) v = v ^ 16'h0001;
            if (v == 16'd0) v = 16'd7;
            run_conversion(v, to_bcd(int'(last)));
            if (i % 2 == 0) test_scan(int'(v));
            last = v;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_1234();
        test_max();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
